tdm_slot_arbiter: RTL and testbench



---
 rtl/tdm_pkg.sv | 15 +
 rtl/onehot_encoder.sv | 24 ++
 rtl/tdm_slot_arbiter.sv | 109 ++++++++++
 tb/tb_tdm_slot_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM slot arbiter.
package tdm_pkg;

    localparam int N_DEF        = 8;
    localparam int FRAME_W_DEF  = 16;
    localparam int MAX_HOLD_DEF = 4;

    typedef enum logic {IDLE, GRANT} state_t;

    // Vectors are zero-extended by the caller; exactly one set bit is valid.
    function automatic logic onehot_ok(input logic [31:0] vec);
        return $countones(vec) == 1;
    endfunction

endpackage

// File: rtl/onehot_encoder.sv
// One-hot to binary index, plus a flag that the input had exactly one bit set.
module onehot_encoder
    import tdm_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0]         vec,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    // OR of set-bit positions: exact for one-hot inputs, zero for zero input.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = idx | IW'(i);
        end
    end

    assign valid = onehot_ok(32'(vec));

endmodule

// File: rtl/tdm_slot_arbiter.sv
// Grants a shared resource to the requester owning the current ring slot,
// with done/timeout release, one-hot integrity check and frame counting.
module tdm_slot_arbiter
    import tdm_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int FRAME_W  = FRAME_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         slot,
    input  logic [N-1:0]         req,
    input  logic                 done,
    input  logic                 err_clr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 busy,
    output logic                 preempt,
    output logic                 timeout,
    output logic [FRAME_W-1:0]   frame_cnt,
    output logic                 slot_err
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    state_t               state;
    logic [N-1:0]         slot_q;
    logic                 served;
    logic [HW-1:0]        hold_cnt;
    logic [$clog2(N)-1:0] slot_idx;
    logic                 slot_ok;
    logic                 slot_chg;
    logic                 served_eff;
    logic                 frame_tick;

    onehot_encoder #(.N(N)) u_enc (
        .vec   (slot),
        .idx   (slot_idx),
        .valid (slot_ok)
    );

    assign slot_chg   = (slot != slot_q);
    // A new slot visit starts unserved, even in the cycle it arrives.
    assign served_eff = slot_chg ? 1'b0 : served;
    assign frame_tick = slot_q[N-1] && slot[0] && slot_ok && onehot_ok(32'(slot_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            slot_q    <= '0;
            served    <= 1'b0;
            hold_cnt  <= '0;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            preempt   <= 1'b0;
            timeout   <= 1'b0;
            frame_cnt <= '0;
            slot_err  <= 1'b0;
        end else begin
            slot_q  <= slot;
            preempt <= 1'b0;
            timeout <= 1'b0;

            if (frame_tick) frame_cnt <= frame_cnt + FRAME_W'(1);

            if (!slot_ok)     slot_err <= 1'b1;
            else if (err_clr) slot_err <= 1'b0;

            case (state)
                IDLE: begin
                    served <= served_eff;
                    if (slot_ok && |(req & slot) && !served_eff) begin
                        state     <= GRANT;
                        grant     <= slot;
                        grant_idx <= slot_idx;
                        hold_cnt  <= HW'(1);
                        busy      <= 1'b1;
                    end
                end
                GRANT: begin
                    if (done || !slot_ok || slot_chg || hold_cnt == HW'(MAX_HOLD)) begin
                        state     <= IDLE;
                        grant     <= '0;
                        grant_idx <= '0;
                        hold_cnt  <= '0;
                        busy      <= 1'b0;
                    end
                    // done outranks both slot change and the hold limit
                    if (done) begin
                        served <= 1'b1;
                    end else if (!slot_ok || slot_chg) begin
                        preempt <= 1'b1;
                        served  <= served_eff;
                    end else if (hold_cnt == HW'(MAX_HOLD)) begin
                        timeout <= 1'b1;
                        served  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                        served   <= served_eff;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_slot_arbiter.sv
// Randomized and directed bench for tdm_slot_arbiter against a cycle-level
// reference model built from slot ownership, visit bookkeeping and hold age.
module tb_tdm_slot_arbiter;

    localparam int NB = 8;
    localparam int MH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] slot = 8'h01;
    logic [NB-1:0] req = '0;
    logic          done = 1'b0;
    logic          err_clr = 1'b0;
    logic [NB-1:0] grant;
    logic [2:0]    grant_idx;
    logic          busy, preempt, timeout, slot_err;
    logic [15:0]   frame_cnt;

    int total = 0;
    int bad = 0;

    // reference model state
    int owner;      // index of granted requester, -1 when idle
    int age;        // cycles the current grant has been visible
    bit visit_done; // current slot visit already consumed a grant
    int prev_slot;
    int frames;
    bit m_err, m_pre, m_to;

    tdm_slot_arbiter u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .slot      (slot),
        .req       (req),
        .done      (done),
        .err_clr   (err_clr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .preempt   (preempt),
        .timeout   (timeout),
        .frame_cnt (frame_cnt),
        .slot_err  (slot_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int popc(input logic [NB-1:0] v);
        int c = 0;
        for (int i = 0; i < NB; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int log2i(input logic [NB-1:0] v);
        for (int i = 0; i < NB; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        owner = -1; age = 0; visit_done = 0; prev_slot = 0;
        frames = 0; m_err = 0; m_pre = 0; m_to = 0;
    endtask

    // Advance the model by one clock with the given inputs.
    task automatic model_step(input logic [NB-1:0] s, input logic [NB-1:0] r,
                              input logic d, input logic c);
        bit ok, fresh;
        ok = (popc(s) == 1);
        fresh = (int'(s) != prev_slot);
        m_pre = 0; m_to = 0;
        if (prev_slot == 8'h80 && s == 8'h01) frames = (frames + 1) % 65536;
        if (!ok) m_err = 1; else if (c) m_err = 0;
        if (fresh) visit_done = 0;
        if (owner < 0) begin
            if (ok && (r & s) != 0 && !visit_done) begin
                owner = log2i(s); age = 1;
            end
        end else if (d) begin
            owner = -1; visit_done = 1;
        end else if (!ok || fresh) begin
            owner = -1; m_pre = 1;
        end else if (age == MH) begin
            owner = -1; m_to = 1; visit_done = 1;
        end else begin
            age++;
        end
        prev_slot = int'(s);
    endtask

    task automatic check_all();
        chk("grant", 32'(grant), owner < 0 ? 32'd0 : 32'd1 << owner);
        chk("grant_idx", 32'(grant_idx), owner < 0 ? 32'd0 : 32'(owner));
        chk("busy", 32'(busy), 32'(owner >= 0));
        chk("preempt", 32'(preempt), 32'(m_pre));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("frame_cnt", 32'(frame_cnt), 32'(frames));
        chk("slot_err", 32'(slot_err), 32'(m_err));
    endtask

    // One clock: check outputs of the previous edge, then apply new inputs.
    task automatic cyc(input logic [NB-1:0] s, input logic [NB-1:0] r,
                       input logic d, input logic c);
        @(negedge clk);
        check_all();
        slot = s; req = r; done = d; err_clr = c;
        model_step(s, r, d, c);
    endtask

    task automatic do_reset();
        slot = 8'h01; req = '0; done = 1'b0; err_clr = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_frame", 32'(frame_cnt), 32'd0);
        check_all();
        rst_n = 1'b1;
        model_step(slot, req, done, err_clr);
    endtask

    initial begin
        int cur;
        int gcnt;
        logic [NB-1:0] s, r;

        do_reset();

        // sweep with no requests: one frame, no grants, no error
        for (int i = 0; i < NB; i++) begin
            cyc(8'h01 << i, 8'h00, 1'b0, 1'b0);
            cyc(8'h01 << i, 8'h00, 1'b0, 1'b0);
        end
        cyc(8'h01, 8'h00, 1'b0, 1'b0);
        cyc(8'h01, 8'h00, 1'b0, 1'b0);
        chk("sweep_frame", 32'(frame_cnt), 32'd1);
        chk("sweep_err", 32'(slot_err), 32'd0);

        // done-terminated grant, no regrant in the same visit
        cyc(8'h04, 8'h04, 1'b0, 1'b0);
        cyc(8'h04, 8'h04, 1'b0, 1'b0);
        chk("done_grant", 32'(grant), 32'h04);
        chk("done_idx", 32'(grant_idx), 32'd2);
        cyc(8'h04, 8'h04, 1'b1, 1'b0);
        cyc(8'h04, 8'h04, 1'b0, 1'b0);
        chk("done_release", 32'(grant), 32'h00);
        for (int i = 0; i < 4; i++) cyc(8'h04, 8'h04, 1'b0, 1'b0);
        chk("done_noregrant", 32'(grant), 32'h00);

        // hold timeout: exactly MH grant cycles
        gcnt = 0;
        cyc(8'h10, 8'h10, 1'b0, 1'b0);
        for (int i = 0; i < MH + 4; i++) begin
            cyc(8'h10, 8'h10, 1'b0, 1'b0);
            if (grant == 8'h10) gcnt++;
            if (i == MH) chk("to_pulse", 32'(timeout), 32'd1);
        end
        chk("to_cycles", 32'(gcnt), 32'(MH));
        chk("to_noregrant", 32'(grant), 32'h00);

        // preempt by slot advance, next slot granted one cycle later
        cyc(8'h02, 8'h06, 1'b0, 1'b0);
        cyc(8'h02, 8'h06, 1'b0, 1'b0);
        chk("pre_grant", 32'(grant), 32'h02);
        cyc(8'h04, 8'h06, 1'b0, 1'b0);
        cyc(8'h04, 8'h06, 1'b0, 1'b0);
        chk("pre_pulse", 32'(preempt), 32'd1);
        chk("pre_drop", 32'(grant), 32'h00);
        cyc(8'h04, 8'h06, 1'b0, 1'b0);
        chk("pre_next", 32'(grant), 32'h04);

        // invalid slot mid-grant, then cleared
        cyc(8'h08, 8'h08, 1'b0, 1'b0);
        cyc(8'h08, 8'h08, 1'b0, 1'b0);
        cyc(8'h05, 8'h08, 1'b0, 1'b0);
        cyc(8'h08, 8'h00, 1'b0, 1'b0);
        chk("bad_err", 32'(slot_err), 32'd1);
        chk("bad_pre", 32'(preempt), 32'd1);
        cyc(8'h08, 8'h00, 1'b0, 1'b1);
        cyc(8'h08, 8'h00, 1'b0, 1'b0);
        chk("err_clr", 32'(slot_err), 32'd0);

        // asynchronous reset mid-grant
        cyc(8'h20, 8'h20, 1'b0, 1'b0);
        cyc(8'h20, 8'h20, 1'b0, 1'b0);
        chk("arst_pre", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_frame", 32'(frame_cnt), 32'd0);
        do_reset();

        // randomized ring traffic with occasional corruption
        cur = 0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) cur = (cur + 1) % NB;
            s = 8'h01 << cur;
            if ($urandom_range(0, 31) == 0) begin
                s = 8'($urandom_range(0, 255));
                if (popc(s) == 1) s = 8'h00;
            end
            r = 8'($urandom);
            if ($urandom_range(0, 1) == 0) r = r | s;
            cyc(s, r, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
        end
        cyc(slot, 8'h00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
